alu_arbiter: RTL and testbench

Shares the single-cycle `alu` datapath between two requesters: port 0 is the core execute stage, port 1 an auxiliary unit such as address generation or a debug/CSR helper. Each port uses a valid/ready request handshake and a registered, held response. Ties go to the ports in round-robin order. The block drives the ALU operand and control inputs, captures `ALUOut` and `branch_enable` into a per-port response register, and zeroes the ALU controls when idle so the ALU output reads 0.

---
 rtl/alu_arbiter.sv | 87 ++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one single-cycle ALU between two valid/ready requesters,
// each with a registered response slot that is held until consumed.
module alu_arbiter #(
    parameter int CTL_W = 10,
    parameter int BRU_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid_0,
    output logic             req_ready_0,
    input  logic [CTL_W-1:0] req_ctl_0,
    input  logic [BRU_W-1:0] req_bructl_0,
    input  logic [31:0]      req_a_0,
    input  logic [31:0]      req_b_0,
    output logic             resp_valid_0,
    input  logic             resp_ready_0,
    output logic [31:0]      resp_data_0,
    output logic             resp_branch_0,
    output logic [15:0]      grant_cnt_0,
    input  logic             req_valid_1,
    output logic             req_ready_1,
    input  logic [CTL_W-1:0] req_ctl_1,
    input  logic [BRU_W-1:0] req_bructl_1,
    input  logic [31:0]      req_a_1,
    input  logic [31:0]      req_b_1,
    output logic             resp_valid_1,
    input  logic             resp_ready_1,
    output logic [31:0]      resp_data_1,
    output logic             resp_branch_1,
    output logic [15:0]      grant_cnt_1,
    output logic [CTL_W-1:0] alu_ctl,
    output logic [BRU_W-1:0] alu_bructl,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_out,
    input  logic             alu_branch
);
    logic last_grant;
    logic elig_0, elig_1, grant_0, grant_1;

    // A full slot is only eligible when it is being drained in the same cycle.
    always_comb begin
        elig_0 = req_valid_0 && (!resp_valid_0 || resp_ready_0);
        elig_1 = req_valid_1 && (!resp_valid_1 || resp_ready_1);
        grant_0 = elig_0 && (!elig_1 || last_grant);
        grant_1 = elig_1 && (!elig_0 || !last_grant);
        req_ready_0 = grant_0;
        req_ready_1 = grant_1;
        alu_ctl = grant_0 ? req_ctl_0 : grant_1 ? req_ctl_1 : '0;
        alu_bructl = grant_0 ? req_bructl_0 : grant_1 ? req_bructl_1 : '0;
        alu_a = grant_0 ? req_a_0 : grant_1 ? req_a_1 : '0;
        alu_b = grant_0 ? req_b_0 : grant_1 ? req_b_1 : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            resp_valid_0 <= 1'b0;
            resp_data_0 <= '0;
            resp_branch_0 <= 1'b0;
            grant_cnt_0 <= '0;
            resp_valid_1 <= 1'b0;
            resp_data_1 <= '0;
            resp_branch_1 <= 1'b0;
            grant_cnt_1 <= '0;
        end else begin
            if (grant_0) begin
                resp_valid_0 <= 1'b1;
                resp_data_0 <= alu_out;
                resp_branch_0 <= alu_branch;
                grant_cnt_0 <= grant_cnt_0 + 16'(grant_cnt_0 != 16'hFFFF);
                last_grant <= 1'b0;
            end else if (resp_ready_0) begin
                resp_valid_0 <= 1'b0;
            end
            if (grant_1) begin
                resp_valid_1 <= 1'b1;
                resp_data_1 <= alu_out;
                resp_branch_1 <= alu_branch;
                grant_cnt_1 <= grant_cnt_1 + 16'(grant_cnt_1 != 16'hFFFF);
                last_grant <= 1'b1;
            end else if (resp_ready_1) begin
                resp_valid_1 <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed plus random stimulus against a queue-based scoreboard and a
// transaction-level model of the arbitration rules; an external ALU model closes the loop.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic req_valid_0, req_ready_0, resp_valid_0, resp_ready_0, resp_branch_0;
    logic req_valid_1, req_ready_1, resp_valid_1, resp_ready_1, resp_branch_1;
    logic [9:0] req_ctl_0, req_ctl_1, alu_ctl;
    logic [6:0] req_bructl_0, req_bructl_1, alu_bructl;
    logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1, resp_data_0, resp_data_1;
    logic [31:0] alu_a, alu_b, alu_out;
    logic alu_branch;
    logic [15:0] grant_cnt_0, grant_cnt_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_ctl_0(req_ctl_0),
        .req_bructl_0(req_bructl_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
        .resp_valid_0(resp_valid_0), .resp_ready_0(resp_ready_0), .resp_data_0(resp_data_0),
        .resp_branch_0(resp_branch_0), .grant_cnt_0(grant_cnt_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_ctl_1(req_ctl_1),
        .req_bructl_1(req_bructl_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
        .resp_valid_1(resp_valid_1), .resp_ready_1(resp_ready_1), .resp_data_1(resp_data_1),
        .resp_branch_1(resp_branch_1), .grant_cnt_1(grant_cnt_1),
        .alu_ctl(alu_ctl), .alu_bructl(alu_bructl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_branch(alu_branch)
    );

    // Behaviour of the shared ALU: {branch, result}; zero controls give zero.
    function automatic logic [32:0] alu_f(input logic [9:0] c, input logic [6:0] br,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic signed [31:0] sra;
        logic t;
        sra = $signed(a) >>> b[4:0];
        r = '0;
        if (c[0]) r = r | {31'b0, a < b};
        if (c[1]) r = r | {31'b0, $signed(a) < $signed(b)};
        if (c[2]) r = r | (a + b);
        if (c[3]) r = r | (a - b);
        if (c[4]) r = r | (a ^ b);
        if (c[5]) r = r | (a | b);
        if (c[6]) r = r | (a & b);
        if (c[7]) r = r | (a << b[4:0]);
        if (c[8]) r = r | (a >> b[4:0]);
        if (c[9]) r = r | sra;
        t = (br[0] && a == b) || (br[1] && a != b) ||
            (br[2] && $signed(a) < $signed(b)) || (br[3] && $signed(a) >= $signed(b)) ||
            (br[4] && a < b) || (br[5] && a >= b);
        return {t, r};
    endfunction

    assign {alu_branch, alu_out} = alu_f(alu_ctl, alu_bructl, alu_a, alu_b);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Transaction-level model: slot occupancy, last winner, counts, expected responses.
    logic [32:0] q0[$], q1[$];
    logic m_full0 = 1'b0, m_full1 = 1'b0, m_last = 1'b1;
    int m_cnt0 = 0, m_cnt1 = 0;
    logic e0, e1, g0, g1;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_full0 = 1'b0; m_full1 = 1'b0; m_last = 1'b1;
            m_cnt0 = 0; m_cnt1 = 0;
            q0.delete(); q1.delete();
        end else begin
            e0 = req_valid_0 && (!m_full0 || resp_ready_0);
            e1 = req_valid_1 && (!m_full1 || resp_ready_1);
            g0 = e0 && (!e1 || m_last);
            g1 = e1 && !g0;
            chk("req_ready_0", 64'(req_ready_0), 64'(g0));
            chk("req_ready_1", 64'(req_ready_1), 64'(g1));
            chk("resp_valid_0", 64'(resp_valid_0), 64'(m_full0));
            chk("resp_valid_1", 64'(resp_valid_1), 64'(m_full1));
            chk("grant_cnt_0", 64'(grant_cnt_0), 64'(m_cnt0));
            chk("grant_cnt_1", 64'(grant_cnt_1), 64'(m_cnt1));
            if (!g0 && !g1)
                chk("alu_idle_zero", 64'(|{alu_ctl, alu_bructl, alu_a, alu_b}), 64'(0));
            if (g0) begin
                q0.push_back(alu_f(req_ctl_0, req_bructl_0, req_a_0, req_b_0));
                m_full0 = 1'b1; m_last = 1'b0;
                if (m_cnt0 < 65535) m_cnt0++;
            end else if (resp_ready_0) m_full0 = 1'b0;
            if (g1) begin
                q1.push_back(alu_f(req_ctl_1, req_bructl_1, req_a_1, req_b_1));
                m_full1 = 1'b1; m_last = 1'b1;
                if (m_cnt1 < 65535) m_cnt1++;
            end else if (resp_ready_1) m_full1 = 1'b0;
        end
    end

    // Monitor: every presented response must match the oldest expected one until consumed.
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid_0) begin
                if (q0.size() == 0) chk("resp_0_unexpected", 64'(1), 64'(0));
                else begin
                    chk("resp_0", 64'({resp_branch_0, resp_data_0}), 64'(q0[0]));
                    if (resp_ready_0) void'(q0.pop_front());
                end
            end
            if (resp_valid_1) begin
                if (q1.size() == 0) chk("resp_1_unexpected", 64'(1), 64'(0));
                else begin
                    chk("resp_1", 64'({resp_branch_1, resp_data_1}), 64'(q1[0]));
                    if (resp_ready_1) void'(q1.pop_front());
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] rand_ctl();
        int k = $urandom_range(0, 10);
        logic [9:0] one = 10'd1;
        return (k == 10) ? 10'd0 : one << k;
    endfunction

    function automatic logic [6:0] rand_bru();
        int k = $urandom_range(0, 6);
        logic [6:0] one = 7'd1;
        return (k == 6) ? 7'd0 : one << k;
    endfunction

    function automatic logic [31:0] rand_op();
        return $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    endfunction

    task automatic set0(input logic v, input logic [9:0] c, input logic [6:0] br,
                        input logic [31:0] a, input logic [31:0] b);
        req_valid_0 = v; req_ctl_0 = c; req_bructl_0 = br; req_a_0 = a; req_b_0 = b;
    endtask

    task automatic set1(input logic v, input logic [9:0] c, input logic [6:0] br,
                        input logic [31:0] a, input logic [31:0] b);
        req_valid_1 = v; req_ctl_1 = c; req_bructl_1 = br; req_a_1 = a; req_b_1 = b;
    endtask

    initial begin
        rst = 1'b1;
        set0(0, 0, 0, 0, 0);
        set1(0, 0, 0, 0, 0);
        resp_ready_0 = 1'b0;
        resp_ready_1 = 1'b0;
        #3;
        chk("rst_resp_valid_0", 64'(resp_valid_0), 64'(0));
        chk("rst_resp_data_0", 64'(resp_data_0), 64'(0));
        chk("rst_grant_cnt_1", 64'(grant_cnt_1), 64'(0));
        chk("rst_alu_ctl", 64'(alu_ctl), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        // post-reset tie: port 0 first, then port 1
        set0(1, 10'h004, 0, 5, 7);
        set1(1, 10'h008, 0, 5, 7);
        resp_ready_0 = 1'b1;
        resp_ready_1 = 1'b1;
        tick;
        chk("tie_data_0", 64'(resp_data_0), 64'd12);
        set0(0, 0, 0, 0, 0);
        tick;
        chk("tie_data_1", 64'(resp_data_1), 64'hFFFFFFFE);
        // back-pressure on port 0 while port 1 streams
        set0(1, 10'h010, 0, 32'hF0F0, 32'h0FF0);
        resp_ready_0 = 1'b0;
        set1(1, 10'h004, 0, 32'd100, 32'd1);
        tick;
        chk("bp_data_0", 64'(resp_data_0), 64'hFF00);
        repeat (3) begin
            #1;
            chk("bp_ready_0", 64'(req_ready_0), 64'(0));
            chk("bp_ready_1", 64'(req_ready_1), 64'(1));
            tick;
            chk("bp_hold_0", 64'({resp_valid_0, resp_data_0}), {31'b0, 1'b1, 32'hFF00});
        end
        // consume and refill in one cycle
        resp_ready_0 = 1'b1;
        set0(1, 10'h080, 0, 1, 4);
        set1(0, 0, 0, 0, 0);
        #1 chk("refill_ready_0", 64'(req_ready_0), 64'(1));
        tick;
        chk("refill_data_0", 64'({resp_valid_0, resp_data_0}), {31'b0, 1'b1, 32'd16});
        set0(0, 0, 0, 0, 0);
        // branch path, left unconsumed
        set1(1, 10'h000, 7'h04, 32'hFFFFFFFF, 32'd1);
        resp_ready_1 = 1'b0;
        tick;
        chk("branch_1", 64'({resp_branch_1, resp_data_1}), {31'b0, 1'b1, 32'd0});
        set1(0, 0, 0, 0, 0);
        // idle outputs, then reset while slot 1 is full
        #1;
        chk("idle_alu", 64'(|{alu_ctl, alu_bructl, alu_a, alu_b}), 64'(0));
        tick;
        chk("held_valid_1", 64'(resp_valid_1), 64'(1));
        #1 rst = 1'b1;
        #1;
        chk("rst_drop_valid_1", 64'(resp_valid_1), 64'(0));
        chk("rst_cnt_1", 64'(grant_cnt_1), 64'(0));
        chk("rst_data_1", 64'({resp_branch_1, resp_data_1}), 64'(0));
        tick;
        rst = 1'b0;
        // random traffic
        repeat (3000) begin
            set0(1'($urandom_range(0, 1)), rand_ctl(), rand_bru(), rand_op(), rand_op());
            set1(1'($urandom_range(0, 1)), rand_ctl(), rand_bru(), rand_op(), rand_op());
            resp_ready_0 = 1'($urandom_range(0, 1));
            resp_ready_1 = 1'($urandom_range(0, 1));
            tick;
        end
        // saturate the port 0 counter
        set1(0, 0, 0, 0, 0);
        resp_ready_0 = 1'b1;
        resp_ready_1 = 1'b1;
        repeat (65540) begin
            set0(1, rand_ctl(), rand_bru(), rand_op(), rand_op());
            tick;
        end
        chk("sat_cnt_0", 64'(grant_cnt_0), 64'hFFFF);
        set0(0, 0, 0, 0, 0);
        tick;
        tick;
        chk("sat_hold_cnt_0", 64'(grant_cnt_0), 64'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
